// File: rtl/dm_responder.sv
// Data-memory responder: edge-triggered request, fixed three-state access,
// sticky illegal-request flag and saturating read/write counters.
module dm_responder #(
    parameter int DEPTH     = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 DM_enable,
    input  logic                 DM_read,
    input  logic                 DM_write,
    input  logic [11:0]          DM_address,
    input  logic [31:0]          DM_in,
    output logic [31:0]          DM_out,
    output logic                 DM_ack,
    output logic                 DM_busy,
    output logic                 dm_error,
    output logic [CNT_WIDTH-1:0] read_count,
    output logic [CNT_WIDTH-1:0] write_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        en_q;
    logic        armed;
    logic        req_det;
    logic        req_rd;
    logic        req_wr;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic        in_range;
    logic        in_access;
    logic        do_rd;
    logic        do_wr;
    logic        do_err;
    logic [AW-1:0] mem_idx;

    logic [31:0] mem [DEPTH];

    // armed blocks a request when enable is already high as reset releases
    assign req_det   = DM_enable & ~en_q & armed;
    assign in_range  = {1'b0, req_addr} < 13'(DEPTH);
    assign in_access = (state == ACCESS);
    assign do_rd     = in_access & req_rd & ~req_wr & in_range;
    assign do_wr     = in_access & req_wr & ~req_rd & in_range;
    assign do_err    = in_access & ~(do_rd | do_wr);
    assign mem_idx   = req_addr[AW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_det) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        DM_ack  = 1'b0;
        DM_busy = 1'b0;
        unique case (state)
            ACCESS: DM_busy = 1'b1;
            DONE: begin
                DM_busy = 1'b1;
                DM_ack  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q     <= 1'b0;
            armed    <= 1'b0;
            req_rd   <= 1'b0;
            req_wr   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
        end else begin
            en_q <= DM_enable;
            if (!DM_enable) armed <= 1'b1;
            if (state == IDLE && req_det) begin
                req_rd   <= DM_read;
                req_wr   <= DM_write;
                req_addr <= DM_address;
                req_data <= DM_in;
            end
        end
    end

    // storage is never reset; an async reset leaves state in IDLE so no write
    always_ff @(posedge clk) begin
        if (do_wr) mem[mem_idx] <= req_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DM_out      <= '0;
            dm_error    <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (do_rd) begin
                DM_out <= mem[mem_idx];
                if (read_count != '1) read_count <= read_count + 1'b1;
            end
            if (do_wr && write_count != '1) begin
                write_count <= write_count + 1'b1;
            end
            if (do_err) dm_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: vector table plus hand sequences
// for held enable, dropped rises, reset mid-access and saturation.
module tb_dm_responder;

    logic        clk;
    logic        rst;
    logic        DM_enable;
    logic        DM_read;
    logic        DM_write;
    logic [11:0] DM_address;
    logic [31:0] DM_in;
    logic [31:0] DM_out;
    logic        DM_ack;
    logic        DM_busy;
    logic        dm_error;
    logic [3:0]  read_count;
    logic [3:0]  write_count;

    int errors = 0;
    int checks = 0;

    dm_responder #(
        .DEPTH(1024),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .DM_enable(DM_enable),
        .DM_read(DM_read),
        .DM_write(DM_write),
        .DM_address(DM_address),
        .DM_in(DM_in),
        .DM_out(DM_out),
        .DM_ack(DM_ack),
        .DM_busy(DM_busy),
        .dm_error(dm_error),
        .read_count(read_count),
        .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_first;
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] din;
        logic [31:0] exp_out;
        logic        exp_err;
        logic [3:0]  exp_rc;
        logic [3:0]  exp_wc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out"}, DM_out, 32'h0);
        chk({tag, " ack"}, {31'b0, DM_ack}, 32'h0);
        chk({tag, " busy"}, {31'b0, DM_busy}, 32'h0);
        chk({tag, " err"}, {31'b0, dm_error}, 32'h0);
        chk({tag, " rc"}, {28'b0, read_count}, 32'h0);
        chk({tag, " wc"}, {28'b0, write_count}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        DM_enable = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One request: low for a sampled edge, rise, then latency checks
    task automatic req(input logic rd, input logic wr,
                       input logic [11:0] addr, input logic [31:0] din);
        @(negedge clk);
        DM_enable  = 1'b0;
        DM_read    = rd;
        DM_write   = wr;
        DM_address = addr;
        DM_in      = din;
        @(negedge clk);
        DM_enable = 1'b1;
        @(posedge clk);
        #1;
        chk("lat k busy", {31'b0, DM_busy}, 32'h1);
        chk("lat k ack", {31'b0, DM_ack}, 32'h0);
        @(negedge clk);
        DM_enable = 1'b0;
        DM_read   = 1'b0;
        DM_write  = 1'b0;
        DM_in     = 32'h0;
        @(posedge clk);
        #1;
        chk("lat k+1 ack", {31'b0, DM_ack}, 32'h1);
        chk("lat k+1 busy", {31'b0, DM_busy}, 32'h1);
        @(posedge clk);
        #1;
        chk("lat k+2 ack", {31'b0, DM_ack}, 32'h0);
        chk("lat k+2 busy", {31'b0, DM_busy}, 32'h0);
    endtask

    initial begin
        int acks;
        logic [7:0] pat;

        tbl[0]  = '{0, 0, 1, 12'h005, 32'hDEADBEEF, 32'h0, 0, 0, 1};
        tbl[1]  = '{0, 1, 0, 12'h005, 32'h0, 32'hDEADBEEF, 0, 1, 1};
        tbl[2]  = '{0, 0, 1, 12'h003, 32'h33333333, 32'hDEADBEEF, 0, 1, 2};
        tbl[3]  = '{0, 0, 1, 12'h007, 32'h11111111, 32'hDEADBEEF, 0, 1, 3};
        tbl[4]  = '{0, 0, 1, 12'h3FF, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 1, 4};
        tbl[5]  = '{0, 1, 0, 12'h003, 32'h0, 32'h33333333, 0, 2, 4};
        tbl[6]  = '{0, 1, 0, 12'h3FF, 32'h0, 32'hA5A5A5A5, 0, 3, 4};
        tbl[7]  = '{0, 1, 1, 12'h003, 32'hFFFFFFFF, 32'hA5A5A5A5, 1, 3, 4};
        tbl[8]  = '{0, 1, 0, 12'h003, 32'h0, 32'h33333333, 1, 4, 4};
        tbl[9]  = '{1, 1, 0, 12'h400, 32'h0, 32'h0, 1, 0, 0};
        tbl[10] = '{0, 1, 0, 12'h3FF, 32'h0, 32'hA5A5A5A5, 1, 1, 0};
        tbl[11] = '{0, 0, 0, 12'h001, 32'h12345678, 32'hA5A5A5A5, 1, 1, 0};

        rst        = 1'b0;
        DM_enable  = 1'b0;
        DM_read    = 1'b0;
        DM_write   = 1'b0;
        DM_address = 12'h0;
        DM_in      = 32'h0;
        #3;
        chk_reset_outputs("init");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst_first) do_reset();
            req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
            chk($sformatf("vec%0d out", i), DM_out, tbl[i].exp_out);
            chk($sformatf("vec%0d err", i), {31'b0, dm_error},
                {31'b0, tbl[i].exp_err});
            chk($sformatf("vec%0d rc", i), {28'b0, read_count},
                {28'b0, tbl[i].exp_rc});
            chk($sformatf("vec%0d wc", i), {28'b0, write_count},
                {28'b0, tbl[i].exp_wc});
        end

        // enable held high for 10 cycles yields exactly one access
        @(negedge clk);
        DM_enable  = 1'b0;
        DM_read    = 1'b1;
        DM_address = 12'h005;
        @(negedge clk);
        DM_enable = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (DM_ack) acks++;
        end
        chk("held acks", acks, 32'd1);
        chk("held out", DM_out, 32'hDEADBEEF);

        // second rise lands while busy and must be dropped
        pat  = 8'b0000_1010;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            DM_enable = pat[i];
            @(posedge clk);
            #1;
            if (DM_ack) acks++;
        end
        chk("drop acks", acks, 32'd1);
        chk("drop rc", {28'b0, read_count}, 32'd3);

        // reset while in ACCESS aborts a write to addr 7
        @(negedge clk);
        DM_enable  = 1'b0;
        DM_read    = 1'b0;
        DM_write   = 1'b1;
        DM_address = 12'h007;
        DM_in      = 32'h22222222;
        @(negedge clk);
        DM_enable = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy pre", {31'b0, DM_busy}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (DM_ack || DM_busy) acks++;
        end
        chk("held thru reset", acks, 32'd0);
        req(1'b1, 1'b0, 12'h007, 32'h0);
        chk("abort mem7", DM_out, 32'h11111111);
        chk("abort wc", {28'b0, write_count}, 32'd0);

        // 4-bit read counter saturates
        do_reset();
        for (int i = 0; i < 20; i++) begin
            req(1'b1, 1'b0, 12'h005, 32'h0);
            if (i == 13) chk("sat rc14", {28'b0, read_count}, 32'hE);
            if (i == 14) chk("sat rc15", {28'b0, read_count}, 32'hF);
        end
        chk("sat rc20", {28'b0, read_count}, 32'hF);
        chk("sat wc", {28'b0, write_count}, 32'h0);
        chk("sat err", {31'b0, dm_error}, 32'h0);
        chk("sat out", DM_out, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
